// File: rtl/wb_decoder_n.sv
// Single-master pipelined Wishbone address decoder and response mux.
// Base/mask windows per slave, lowest index wins on overlap. One outstanding
// transaction, per-transaction timeout, and sticky error address/cause capture.
module wb_decoder_n #(
  parameter int unsigned      NS         = 4,
  parameter int unsigned      AW         = 32,
  parameter int unsigned      DW         = 32,
  parameter logic [NS*AW-1:0] SLAVE_BASE = '0,
  parameter logic [NS*AW-1:0] SLAVE_MASK = '1,
  parameter int unsigned      TIMEOUT    = 255
) (
  input  logic             i_clk,
  input  logic             i_reset,
  // master side
  input  logic             i_wb_cyc,
  input  logic             i_wb_stb,
  input  logic             i_wb_we,
  input  logic [AW-1:0]    i_wb_addr,
  input  logic [DW-1:0]    i_wb_data,
  input  logic [DW/8-1:0]  i_wb_sel,
  output logic             o_wb_stall,
  output logic             o_wb_ack,
  output logic             o_wb_err,
  output logic [DW-1:0]    o_wb_data,
  output logic [AW-1:0]    o_wb_err_addr,
  output logic [1:0]       o_wb_err_cause,
  // slave side
  output logic [AW-1:0]    o_s_addr,
  output logic [DW-1:0]    o_s_data,
  output logic [DW/8-1:0]  o_s_sel,
  output logic             o_s_we,
  output logic [NS-1:0]    o_s_cyc,
  output logic [NS-1:0]    o_s_stb,
  input  logic [NS-1:0]    i_s_ack,
  input  logic [NS-1:0]    i_s_err,
  input  logic [NS-1:0]    i_s_stall,
  input  logic [NS*DW-1:0] i_s_data
);

  localparam int unsigned SW = (NS > 1) ? $clog2(NS) : 1;
  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_MAX  = '1;
  // Timeout fires on the edge where the counter would reach TIMEOUT.
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  localparam logic [1:0] CAUSE_UNMAPPED = 2'b01;
  localparam logic [1:0] CAUSE_SLAVE    = 2'b10;
  localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e          state;
  logic [SW-1:0]   sel;
  logic [CW-1:0]   cnt;

  logic            dec_hit;
  logic [SW-1:0]   dec_sel;
  logic [NS-1:0]   dec_oh;
  logic [NS-1:0]   sel_oh;
  logic            busy;
  logic            s_ack;
  logic            s_err;
  logic            s_stall;
  logic [DW-1:0]   s_rdata;
  logic [CW-1:0]   cnt_inc;
  logic            to_hit;

  // Address decode: scan high to low so the lowest matching index wins
  always_comb begin
    dec_hit = 1'b0;
    dec_sel = '0;
    for (int k = NS - 1; k >= 0; k--) begin
      if ((i_wb_addr & SLAVE_MASK[k*AW +: AW]) ==
          (SLAVE_BASE[k*AW +: AW] & SLAVE_MASK[k*AW +: AW])) begin
        dec_hit = 1'b1;
        dec_sel = SW'(k);
      end
    end
  end

  // One-hot forms of the decoded and the latched slave index
  always_comb begin
    dec_oh         = '0;
    dec_oh[dec_sel] = 1'b1;
    sel_oh         = '0;
    sel_oh[sel]    = 1'b1;
  end

  assign busy    = (state == StIssue) || (state == StWait);
  assign s_ack   = i_s_ack[sel];
  assign s_err   = i_s_err[sel];
  assign s_stall = i_s_stall[sel];
  assign s_rdata = i_s_data[sel*DW +: DW];
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
  assign to_hit  = (TIMEOUT != 0) && (cnt >= CNT_LAST);

  // Cycle follows the master combinationally so an abort releases the slave at once
  assign o_s_cyc    = (i_wb_cyc && busy) ? sel_oh : '0;
  assign o_wb_stall = (state != StIdle);

  // Transaction FSM with registered request copies, responses and error capture
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state          <= StIdle;
      sel            <= '0;
      cnt            <= '0;
      o_wb_ack       <= 1'b0;
      o_wb_err       <= 1'b0;
      o_wb_data      <= '0;
      o_wb_err_addr  <= '0;
      o_wb_err_cause <= '0;
      o_s_addr       <= '0;
      o_s_data       <= '0;
      o_s_sel        <= '0;
      o_s_we         <= 1'b0;
      o_s_stb        <= '0;
    end else begin
      // Responses are single-cycle pulses; read data is zero outside ack
      o_wb_ack  <= 1'b0;
      o_wb_err  <= 1'b0;
      o_wb_data <= '0;
      unique case (state)
        StIdle: begin
          if (i_wb_cyc && i_wb_stb) begin
            o_s_addr <= i_wb_addr;
            o_s_data <= i_wb_data;
            o_s_sel  <= i_wb_sel;
            o_s_we   <= i_wb_we;
            cnt      <= '0;
            if (dec_hit) begin
              sel     <= dec_sel;
              o_s_stb <= dec_oh;
              state   <= StIssue;
            end else begin
              o_wb_err       <= 1'b1;
              o_wb_err_addr  <= i_wb_addr;
              o_wb_err_cause <= CAUSE_UNMAPPED;
              state          <= StResp;
            end
          end
        end
        StIssue: begin
          if (!i_wb_cyc) begin
            o_s_stb <= '0;
            state   <= StIdle;
          end else if (!s_stall) begin
            o_s_stb <= '0;
            cnt     <= cnt_inc;
            if (s_err) begin
              o_wb_err       <= 1'b1;
              o_wb_err_addr  <= o_s_addr;
              o_wb_err_cause <= CAUSE_SLAVE;
              state          <= StResp;
            end else if (s_ack) begin
              o_wb_ack  <= 1'b1;
              o_wb_data <= s_rdata;
              state     <= StResp;
            end else if (to_hit) begin
              o_wb_err       <= 1'b1;
              o_wb_err_addr  <= o_s_addr;
              o_wb_err_cause <= CAUSE_TIMEOUT;
              state          <= StResp;
            end else begin
              state <= StWait;
            end
          end else if (to_hit) begin
            o_s_stb        <= '0;
            o_wb_err       <= 1'b1;
            o_wb_err_addr  <= o_s_addr;
            o_wb_err_cause <= CAUSE_TIMEOUT;
            state          <= StResp;
          end else begin
            cnt <= cnt_inc;
          end
        end
        StWait: begin
          if (!i_wb_cyc) begin
            state <= StIdle;
          end else if (s_err) begin
            o_wb_err       <= 1'b1;
            o_wb_err_addr  <= o_s_addr;
            o_wb_err_cause <= CAUSE_SLAVE;
            state          <= StResp;
          end else if (s_ack) begin
            o_wb_ack  <= 1'b1;
            o_wb_data <= s_rdata;
            state     <= StResp;
          end else if (to_hit) begin
            o_wb_err       <= 1'b1;
            o_wb_err_addr  <= o_s_addr;
            o_wb_err_cause <= CAUSE_TIMEOUT;
            state          <= StResp;
          end else begin
            cnt <= cnt_inc;
          end
        end
        StResp: begin
          state <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_decoder_n.sv
// Directed bench for wb_decoder_n: table of single transactions plus hand-written
// abort and asynchronous-reset sequences. A small slave model serves all slaves.
module tb_wb_decoder_n;

  localparam int unsigned NS = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              wb_cyc = 1'b0, wb_stb = 1'b0, wb_we = 1'b0;
  logic [AW-1:0]     wb_addr = '0;
  logic [DW-1:0]     wb_wdata = '0;
  logic [DW/8-1:0]   wb_sel = '0;
  logic              wb_stall, wb_ack, wb_err;
  logic [DW-1:0]     wb_rdata;
  logic [AW-1:0]     err_addr;
  logic [1:0]        err_cause;
  logic [AW-1:0]     s_addr;
  logic [DW-1:0]     s_wdata;
  logic [DW/8-1:0]   s_sel;
  logic              s_we;
  logic [NS-1:0]     s_cyc, s_stb, s_ack, s_err, s_stall;
  logic [NS*DW-1:0]  s_rdata;

  assign s_rdata = {32'h3333_3333, 32'hDEAD_BEEF, 32'h1111_1111, 32'h0000_A0A0};

  wb_decoder_n #(
    .NS        (NS),
    .AW        (AW),
    .DW        (DW),
    .SLAVE_BASE({32'h8000_0000, 32'h8000_0020, 32'h1000_0000, 32'h0000_1000}),
    .SLAVE_MASK({32'hFF00_0000, 32'hFFFF_FFF0, 32'hFFFF_0000, 32'hFFFF_F000}),
    .TIMEOUT   (TO)
  ) dut (
    .i_clk         (clk),
    .i_reset       (rst),
    .i_wb_cyc      (wb_cyc),
    .i_wb_stb      (wb_stb),
    .i_wb_we       (wb_we),
    .i_wb_addr     (wb_addr),
    .i_wb_data     (wb_wdata),
    .i_wb_sel      (wb_sel),
    .o_wb_stall    (wb_stall),
    .o_wb_ack      (wb_ack),
    .o_wb_err      (wb_err),
    .o_wb_data     (wb_rdata),
    .o_wb_err_addr (err_addr),
    .o_wb_err_cause(err_cause),
    .o_s_addr      (s_addr),
    .o_s_data      (s_wdata),
    .o_s_sel       (s_sel),
    .o_s_we        (s_we),
    .o_s_cyc       (s_cyc),
    .o_s_stb       (s_stb),
    .i_s_ack       (s_ack),
    .i_s_err       (s_err),
    .i_s_stall     (s_stall),
    .i_s_data      (s_rdata)
  );

  always #5 clk = ~clk;

  // Slave model: stall for cfg_stall strobe cycles, respond cfg_lat cycles after
  // the strobe is taken (0 = same cycle), on whichever slave has cyc.
  int   cfg_stall = 0, cfg_lat = 0;
  logic cfg_ack = 1'b1, cfg_err = 1'b0, cfg_never = 1'b0;
  int   stall_seen, wc;
  logic waiting;
  logic stalled, taken, resp_now;

  assign stalled  = (s_stb != '0) && (stall_seen < cfg_stall);
  assign taken    = (s_stb != '0) && !stalled;
  assign resp_now = !cfg_never && ((taken && cfg_lat == 0) || (waiting && wc == 0));
  assign s_stall  = stalled ? s_stb : '0;
  assign s_ack    = (resp_now && cfg_ack) ? s_cyc : '0;
  assign s_err    = (resp_now && cfg_err) ? s_cyc : '0;

  always @(posedge clk) begin
    if (rst || s_stb == '0) stall_seen <= 0;
    else if (stalled) stall_seen <= stall_seen + 1;
    if (rst || s_cyc == '0) begin
      waiting <= 1'b0;
      wc      <= 0;
    end else if (taken && cfg_lat > 0) begin
      waiting <= 1'b1;
      wc      <= cfg_lat - 1;
    end else if (waiting && wc > 0) begin
      wc <= wc - 1;
    end
  end

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  sel;
    int          stall;
    int          lat;
    logic        ack;
    logic        err;
    logic        never;
    logic [3:0]  exp_stb;    // o_s_stb in cycle 1
    int          exp_cyc;    // cycle of the response
    int          exp_stbn;   // cycles with a strobe high
    logic        exp_ack;    // 1 ack, 0 err
    logic [1:0]  exp_cause;
    logic [31:0] exp_data;
  } vec_t;

  int checks = 0;
  int failures = 0;
  logic [31:0] m_err_addr = '0;
  logic [1:0]  m_err_cause = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int   resp_cyc = 0, nresp = 0, stbn = 0;
    logic got_ack = 1'b0, got_err = 1'b0, hold_bad = 1'b0, stall_after = 1'b1;
    logic [31:0] got_data = '0;
    logic [3:0]  stb1 = '0, cyc_at_resp = '1;
    cfg_stall = v.stall; cfg_lat = v.lat; cfg_ack = v.ack; cfg_err = v.err;
    cfg_never = v.never;
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = v.we; wb_addr = v.addr;
    wb_wdata = v.wdata; wb_sel = v.sel;
    for (int n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (n == 1) begin
        stb1 = s_stb;
        wb_stb = 1'b0; wb_addr = ~v.addr; wb_wdata = ~v.wdata; wb_sel = ~v.sel;
        wb_we = ~v.we;
      end
      if (s_stb != '0) begin
        stbn++;
        if (s_addr !== v.addr || s_wdata !== v.wdata || s_sel !== v.sel || s_we !== v.we)
          hold_bad = 1'b1;
      end
      if (wb_ack || wb_err) begin
        nresp++;
        if (resp_cyc == 0) begin
          resp_cyc = n; got_ack = wb_ack; got_err = wb_err; got_data = wb_rdata;
          cyc_at_resp = s_cyc;
          wb_cyc = 1'b0;
        end
      end
      if (resp_cyc != 0 && n == resp_cyc + 1) stall_after = wb_stall;
      if (resp_cyc != 0 && n >= resp_cyc + 2) break;
    end
    wb_cyc = 1'b0;
    if (!v.exp_ack) begin
      m_err_addr = v.addr; m_err_cause = v.exp_cause;
    end
    check($sformatf("v%0d stb_cycle1", idx), 64'(stb1), 64'(v.exp_stb));
    check($sformatf("v%0d resp_cycle", idx), 64'(resp_cyc), 64'(v.exp_cyc));
    check($sformatf("v%0d ack", idx), 64'(got_ack), 64'(v.exp_ack));
    check($sformatf("v%0d err", idx), 64'(got_err), 64'(!v.exp_ack));
    check($sformatf("v%0d rdata", idx), 64'(got_data), 64'(v.exp_data));
    check($sformatf("v%0d cyc_at_resp", idx), 64'(cyc_at_resp), 64'(0));
    check($sformatf("v%0d resp_count", idx), 64'(nresp), 64'(1));
    check($sformatf("v%0d stb_cycles", idx), 64'(stbn), 64'(v.exp_stbn));
    check($sformatf("v%0d req_hold", idx), 64'(hold_bad), 64'(0));
    check($sformatf("v%0d stall_after", idx), 64'(stall_after), 64'(0));
    check($sformatf("v%0d err_addr", idx), 64'(err_addr), 64'(m_err_addr));
    check($sformatf("v%0d err_cause", idx), 64'(err_cause), 64'(m_err_cause));
  endtask

  vec_t vecs[10];
  int   nrsp;

  initial begin
    //            addr          we    wdata         sel      st lat ack   err   nev
    //            exp_stb  cyc stbn exp_ack cause  data
    vecs[0] = '{32'h8000_0024, 1'b0, 32'h0,        4'b1111, 0, 0, 1'b1, 1'b0, 1'b0,
                4'b0100, 2, 1, 1'b1, 2'b00, 32'hDEAD_BEEF};
    vecs[1] = '{32'h0000_1008, 1'b1, 32'h1234_5678, 4'b0011, 3, 2, 1'b1, 1'b0, 1'b0,
                4'b0001, 7, 4, 1'b1, 2'b00, 32'h0000_A0A0};
    vecs[2] = '{32'h4000_0000, 1'b0, 32'h0,        4'b1111, 0, 0, 1'b1, 1'b0, 1'b0,
                4'b0000, 1, 0, 1'b0, 2'b01, 32'h0};
    vecs[3] = '{32'h1000_0040, 1'b0, 32'h0,        4'b1111, 0, 0, 1'b1, 1'b0, 1'b1,
                4'b0010, 9, 1, 1'b0, 2'b11, 32'h0};
    vecs[4] = '{32'h80FF_0000, 1'b0, 32'h0,        4'b1111, 0, 1, 1'b1, 1'b0, 1'b0,
                4'b1000, 3, 1, 1'b1, 2'b00, 32'h3333_3333};
    vecs[5] = '{32'h1000_0004, 1'b1, 32'hCAFE_F00D, 4'b1000, 0, 0, 1'b1, 1'b1, 1'b0,
                4'b0010, 2, 1, 1'b0, 2'b10, 32'h0};
    vecs[6] = '{32'h0000_1FFC, 1'b1, 32'h0BAD_0BAD, 4'b1111, 0, 3, 1'b0, 1'b1, 1'b0,
                4'b0001, 5, 1, 1'b0, 2'b10, 32'h0};
    vecs[7] = '{32'h0000_1010, 1'b0, 32'h0,        4'b1111, 20, 0, 1'b1, 1'b0, 1'b0,
                4'b0001, 9, 8, 1'b0, 2'b11, 32'h0};
    vecs[8] = '{32'h8000_002F, 1'b0, 32'h0,        4'b1111, 1, 0, 1'b1, 1'b0, 1'b0,
                4'b0100, 3, 2, 1'b1, 2'b00, 32'hDEAD_BEEF};
    vecs[9] = '{32'h8000_0030, 1'b0, 32'h0,        4'b1111, 0, 0, 1'b1, 1'b0, 1'b0,
                4'b1000, 2, 1, 1'b1, 2'b00, 32'h3333_3333};

    // Reset state
    repeat (2) @(negedge clk);
    check("reset outputs", {wb_stall, wb_ack, wb_err, s_we, s_cyc, s_stb, err_cause},
          64'(0));
    check("reset data", {wb_rdata, err_addr}, 64'(0));
    rst = 1'b0;

    for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

    // Abort during WAIT: slave 1 never answers, master drops cyc in cycle 3
    cfg_stall = 0; cfg_lat = 0; cfg_ack = 1'b1; cfg_err = 1'b0; cfg_never = 1'b1;
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = 1'b0; wb_addr = 32'h1000_0100;
    @(negedge clk);
    wb_stb = 1'b0;
    @(negedge clk);
    check("abort cyc in wait", 64'(s_cyc), 64'(4'b0010));
    @(negedge clk);
    wb_cyc = 1'b0;
    #1;
    check("abort cyc drop", 64'(s_cyc), 64'(0));
    nrsp = 0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (wb_ack || wb_err) nrsp++;
      if (n == 0) check("abort idle", 64'(wb_stall), 64'(0));
    end
    check("abort no resp", 64'(nrsp), 64'(0));
    check("abort err regs", {err_addr, 30'h0, err_cause}, {m_err_addr, 30'h0, m_err_cause});
    run_vec(10, vecs[0]);

    // Asynchronous reset mid-ISSUE: slave 0 stalls indefinitely
    cfg_stall = 50; cfg_lat = 0; cfg_ack = 1'b1; cfg_err = 1'b0; cfg_never = 1'b0;
    @(negedge clk);
    wb_cyc = 1'b1; wb_stb = 1'b1; wb_addr = 32'h0000_1234;
    @(negedge clk);
    wb_stb = 1'b0;
    @(negedge clk);
    check("issue stb before rst", 64'(s_stb), 64'(4'b0001));
    rst = 1'b1;
    #1;
    check("rst cyc stb", {s_cyc, s_stb}, 64'(0));
    check("rst outputs", {wb_stall, wb_ack, wb_err, s_we, err_cause, s_sel}, 64'(0));
    check("rst addr", {s_addr, err_addr}, 64'(0));
    check("rst data", {s_wdata, wb_rdata}, 64'(0));
    m_err_addr = '0; m_err_cause = '0;
    @(negedge clk);
    wb_cyc = 1'b0;
    rst = 1'b0;
    run_vec(11, vecs[4]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
